// File: rtl/hflip_augment.sv
// hflip_augment: ping-pong row buffer that re-emits each image row reversed or in order
module hflip_augment #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flip_en,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   pixel_in_valid,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_out_valid,
    output logic                   in_image_done,
    output logic                   image_done,
    output logic                   overflow
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    logic [PIXEL_WIDTH-1:0] mem_q [2][IMG_W];
    logic [CW-1:0]          in_col_q, out_col_q, rd_idx;
    logic [RW-1:0]          in_row_q;
    logic                   wsel_q, rsel_q, img_flip_q;
    logic [1:0]             full_q, full_d, row_flip_q, row_last_q;
    state_t                 state_q;
    logic [PIXEL_WIDTH-1:0] pixel_out_q;
    logic                   pixel_out_valid_q, in_image_done_q, image_done_q, overflow_q;
    logic                   releasing, wr_ok, in_col_last, in_row_last, img_start, cur_flip;

    assign in_col_last = in_col_q == CW'(IMG_W - 1);
    assign in_row_last = in_row_q == RW'(IMG_H - 1);
    assign img_start   = (in_col_q == '0) && (in_row_q == '0);
    assign cur_flip    = img_start ? flip_en : img_flip_q;
    // The buffer being read hands back its slot on the edge its last column is read
    assign releasing   = (state_q == EMIT) && (out_col_q == CW'(IMG_W - 1));
    assign wr_ok       = pixel_in_valid && (!full_q[wsel_q] || (releasing && rsel_q == wsel_q));
    assign rd_idx      = row_flip_q[rsel_q] ? CW'(IMG_W - 1) - out_col_q : out_col_q;

    assign pixel_out       = pixel_out_q;
    assign pixel_out_valid = pixel_out_valid_q;
    assign in_image_done   = in_image_done_q;
    assign image_done      = image_done_q;
    assign overflow        = overflow_q;

    // Full flags: release by the reader first, then a completed row from the writer
    always_comb begin
        full_d = full_q;
        if (releasing) full_d[rsel_q] = 1'b0;
        if (wr_ok && in_col_last) full_d[wsel_q] = 1'b1;
    end

    // Row storage; no reset needed since full flags gate every read
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wsel_q][in_col_q] <= pixel_in;
    end

    // Write side: raster counters, per-row flip/last tags, overflow and input-done flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_col_q        <= '0;
            in_row_q        <= '0;
            wsel_q          <= 1'b0;
            img_flip_q      <= 1'b0;
            full_q          <= 2'b00;
            row_flip_q      <= 2'b00;
            row_last_q      <= 2'b00;
            overflow_q      <= 1'b0;
            in_image_done_q <= 1'b0;
        end else begin
            full_q          <= full_d;
            in_image_done_q <= wr_ok && in_col_last && in_row_last;
            if (pixel_in_valid && !wr_ok) overflow_q <= 1'b1;
            if (wr_ok) begin
                in_col_q <= in_col_last ? '0 : in_col_q + 1'b1;
                if (img_start) img_flip_q <= flip_en;
                if (in_col_last) begin
                    row_flip_q[wsel_q] <= cur_flip;
                    row_last_q[wsel_q] <= in_row_last;
                    wsel_q             <= ~wsel_q;
                    in_row_q           <= in_row_last ? '0 : in_row_q + 1'b1;
                end
            end
        end
    end

    // Read FSM: streams a full row out, chaining straight into the other buffer when ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            rsel_q            <= 1'b0;
            out_col_q         <= '0;
            pixel_out_q       <= '0;
            pixel_out_valid_q <= 1'b0;
            image_done_q      <= 1'b0;
        end else begin
            pixel_out_valid_q <= state_q == EMIT;
            image_done_q      <= releasing && row_last_q[rsel_q];
            case (state_q)
                IDLE: begin
                    if (full_q[rsel_q]) begin
                        state_q   <= EMIT;
                        out_col_q <= '0;
                    end
                end
                EMIT: begin
                    pixel_out_q <= mem_q[rsel_q][rd_idx];
                    if (releasing) begin
                        out_col_q <= '0;
                        rsel_q    <= ~rsel_q;
                        state_q   <= full_q[~rsel_q] ? EMIT : IDLE;
                    end else begin
                        out_col_q <= out_col_q + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hflip_augment.sv
// tb_hflip_augment: randomized checks of hflip_augment against a row-queue reference model
module tb_hflip_augment;
    localparam int W = 28;
    localparam int H = 28;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flip_en = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       pixel_in_valid = 1'b0;
    logic [7:0] pixel_out;
    logic       pixel_out_valid, in_image_done, image_done, overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_col = 0, m_row = 0, run = 0, in_done_edge = -1;
    bit m_flip = 1'b0;
    bit mon_en = 1'b1;
    int rowbuf [W];
    int exp_px [$];
    bit exp_done [$];
    int row_end [$];

    hflip_augment #(.PIXEL_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .flip_en(flip_en), .pixel_in(pixel_in),
        .pixel_in_valid(pixel_in_valid), .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
        .in_image_done(in_image_done), .image_done(image_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one input cycle and update the reference model with the pixel if valid
    task automatic send(input bit v, input logic [7:0] px, input bit f);
        @(negedge clk);
        pixel_in_valid = v;
        pixel_in = px;
        flip_en = f;
        if (v) begin
            if (m_col == 0 && m_row == 0) m_flip = f;
            rowbuf[m_col] = int'(px);
            if (m_col == W - 1) begin
                for (int c = 0; c < W; c++) begin
                    exp_px.push_back(rowbuf[m_flip ? W - 1 - c : c]);
                    exp_done.push_back(m_row == H - 1 && c == W - 1);
                end
                row_end.push_back(cyc + 1);
                if (m_row == H - 1) in_done_edge = cyc + 1;
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00, 1'($urandom));
    endtask

    task automatic image(input bit f, input bit gaps, input bit rnd_px, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps) while ($urandom_range(1, 0) == 1) send(1'b0, 8'($urandom), 1'($urandom));
            send(1'b1, rnd_px ? 8'($urandom) : 8'(i % 256), (i == 0) ? f : 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pixel_in_valid = 1'b0;
        exp_px.delete();
        exp_done.delete();
        row_end.delete();
        m_col = 0;
        m_row = 0;
        run = 0;
        in_done_edge = -1;
        @(negedge clk);
        check("rst_pixel_out", 32'(pixel_out), 0);
        check("rst_out_valid", 32'(pixel_out_valid), 0);
        check("rst_in_image_done", 32'(in_image_done), 0);
        check("rst_image_done", 32'(image_done), 0);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
    endtask

    // Output monitor: data order, latency, burst continuity and done pulses
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (pixel_out_valid) begin
                if (exp_px.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    if (run == 0) check("latency", 32'(cyc - row_end.pop_front()), 2);
                    check("pixel", 32'(pixel_out), 32'(exp_px.pop_front()));
                    check("image_done", 32'(image_done), 32'(exp_done.pop_front()));
                end
                run = (run == W - 1) ? 0 : run + 1;
            end else begin
                if (run != 0) begin
                    check("burst_gap", 32'(run), 0);
                    run = 0;
                end
                if (image_done) check("done_without_valid", 32'(image_done), 0);
            end
            if (in_image_done || cyc == in_done_edge)
                check("in_image_done", 32'(in_image_done), 32'(cyc == in_done_edge));
        end
    end

    initial begin
        do_reset();
        image(1'b0, 1'b0, 1'b0, W * H);
        idle(W + 6);
        check("drained_pass", 32'(exp_px.size()), 0);
        image(1'b1, 1'b0, 1'b0, W * H);
        idle(W + 6);
        check("drained_flip", 32'(exp_px.size()), 0);
        image(1'b1, 1'b0, 1'b0, W * H);
        image(1'b0, 1'b0, 1'b0, W * H);
        idle(W + 6);
        check("drained_b2b", 32'(exp_px.size()), 0);
        image(1'b0, 1'b1, 1'b1, W * H);
        image(1'b1, 1'b1, 1'b1, W * H);
        idle(W + 6);
        check("drained_gaps", 32'(exp_px.size()), 0);
        check("overflow_clean", 32'(overflow), 0);
        image(1'b1, 1'b0, 1'b0, 300);
        do_reset();
        image(1'b1, 1'b1, 1'b1, W * H);
        idle(W + 6);
        check("drained_after_reset", 32'(exp_px.size()), 0);
        check("overflow_clean2", 32'(overflow), 0);
        mon_en = 1'b0;
        do_reset();
        @(negedge clk);
        force dut.full_q = 2'b11;
        pixel_in_valid = 1'b1;
        pixel_in = 8'hAA;
        @(negedge clk);
        pixel_in_valid = 1'b0;
        check("overflow_set", 32'(overflow), 1);
        check("dropped_col_held", 32'(dut.in_col_q), 0);
        release dut.full_q;
        repeat (2 * W) @(negedge clk);
        check("overflow_sticky", 32'(overflow), 1);
        do_reset();
        mon_en = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
